// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler: picks one ready reservation-station entry per cycle into a registered ALU slot.
// Latency: 1 cycle from grant to alu_valid. Backpressure: alu_ready=0 holds the slot bit-stable and blocks grants.
// Flush empties the slot without granting. stall_cnt counts blocked full-slot cycles and saturates.
module alu_issue_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [4*NUM_REQ-1:0]      req_ctrl,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_b,
    input  logic [TAG_W*NUM_REQ-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      alu_valid,
    output logic [3:0]                alu_ctrl,
    output logic [DATA_W-1:0]         alu_op_a,
    output logic [DATA_W-1:0]         alu_op_b,
    output logic [TAG_W-1:0]          alu_tag,
    input  logic                      alu_ready,
    output logic [15:0]               stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               win_hit;
    logic               can_issue;
    logic [3:0]         win_ctrl;
    logic [DATA_W-1:0]  win_op_a;
    logic [DATA_W-1:0]  win_op_b;
    logic [TAG_W-1:0]   win_tag;

    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    // reset_n gates issue so grant is forced low asynchronously during reset
    assign can_issue = ((state_q == EMPTY) || alu_ready) && !flush && reset_n;
    assign alu_valid = (state_q == FULL);

    always_comb begin
        win_hit = 1'b0;
        win_idx = rr_ptr;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!win_hit && req_valid[rr_slot(rr_ptr, k)]) begin
                    win_hit = 1'b1;
                    win_idx = rr_slot(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        win_ctrl = req_ctrl[int'(win_idx)*4 +: 4];
        win_op_a = req_op_a[int'(win_idx)*DATA_W +: DATA_W];
        win_op_b = req_op_b[int'(win_idx)*DATA_W +: DATA_W];
        win_tag  = req_tag[int'(win_idx)*TAG_W +: TAG_W];
        if (win_hit) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (win_hit) begin
            state_d = FULL;
        end else if (alu_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ctrl is forwarded opaque; 4'b1111 is simply the idle encoding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_ctrl <= 4'b1111;
            alu_op_a <= '0;
            alu_op_b <= '0;
            alu_tag  <= '0;
            rr_ptr   <= '0;
        end else if (win_hit) begin
            alu_ctrl <= win_ctrl;
            alu_op_a <= win_op_a;
            alu_op_b <= win_op_b;
            alu_tag  <= win_tag;
            rr_ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state_q == FULL) && !alu_ready && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios plus random traffic checked against a behavioural slot model.
module tb_alu_issue_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [4*N-1:0]    req_ctrl;
    logic [DW*N-1:0]   req_op_a;
    logic [DW*N-1:0]   req_op_b;
    logic [TW*N-1:0]   req_tag;
    logic [N-1:0]      grant;
    logic              alu_valid;
    logic [3:0]        alu_ctrl;
    logic [DW-1:0]     alu_op_a;
    logic [DW-1:0]     alu_op_b;
    logic [TW-1:0]     alu_tag;
    logic              alu_ready;
    logic [15:0]       stall_cnt;

    alu_issue_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ctrl(req_ctrl), .req_op_a(req_op_a),
        .req_op_b(req_op_b), .req_tag(req_tag), .grant(grant),
        .alu_valid(alu_valid), .alu_ctrl(alu_ctrl), .alu_op_a(alu_op_a),
        .alu_op_b(alu_op_b), .alu_tag(alu_tag), .alu_ready(alu_ready),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: slot contents, pointer and stall counter as plain values
    bit          m_full;
    logic [3:0]  m_ctrl;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic [TW-1:0] m_tag;
    int          m_ptr;
    int          m_stall;
    logic [N-1:0] last_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_ctrl  = 4'b1111;
        m_a     = '0;
        m_b     = '0;
        m_tag   = '0;
        m_ptr   = 0;
        m_stall = 0;
    endtask

    task automatic check_slot(input string tag);
        chk({tag, "_valid"}, alu_valid, m_full);
        chk({tag, "_ctrl"}, alu_ctrl, m_ctrl);
        chk({tag, "_op_a"}, alu_op_a, m_a);
        chk({tag, "_op_b"}, alu_op_b, m_b);
        chk({tag, "_tag"}, alu_tag, m_tag);
        chk({tag, "_stall"}, stall_cnt, m_stall);
        chk({tag, "_ptr"}, dut.rr_ptr, m_ptr);
    endtask

    // One clock cycle: drive at posedge+1, check grant mid-cycle, check slot at next posedge+1.
    task automatic step(input logic [N-1:0] rv, input logic [4*N-1:0] c,
                        input logic [DW*N-1:0] a, input logic [DW*N-1:0] b,
                        input logic [TW*N-1:0] t, input logic rdy, input logic fl);
        int win;
        logic [N-1:0] exp_g;
        req_valid = rv; req_ctrl = c; req_op_a = a; req_op_b = b; req_tag = t;
        alu_ready = rdy; flush = fl;
        #3;
        win = -1;
        if (!fl && (!m_full || rdy)) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && rv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        exp_g = '0;
        if (win >= 0) exp_g[win] = 1'b1;
        chk("grant", grant, exp_g);
        last_grant = grant;
        @(posedge clk);
        #1;
        if (fl) begin
            m_full = 1'b0;
        end else if (m_full && !rdy) begin
            if (m_stall < 16'hFFFF) m_stall++;
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_ctrl = c[win*4 +: 4];
            m_a    = a[win*DW +: DW];
            m_b    = b[win*DW +: DW];
            m_tag  = t[win*TW +: TW];
            m_ptr  = (win + 1) % N;
        end else begin
            m_full = 1'b0;
        end
        check_slot("slot");
    endtask

    function automatic logic [DW*N-1:0] rnd_ops();
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic rstep(input logic [N-1:0] rv, input logic rdy, input logic fl);
        logic [4*N-1:0] c;
        logic [TW*N-1:0] t;
        c = 16'($urandom);
        t = 24'($urandom);
        step(rv, c, rnd_ops(), rnd_ops(), t, rdy, fl);
    endtask

    logic [N-1:0] exp_seq [5];
    int n_fill;

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        reset_n = 1'b0; flush = 1'b0; alu_ready = 1'b1;
        req_valid = 4'b1111; req_ctrl = '0; req_op_a = '0; req_op_b = '0; req_tag = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 4'b0000);
        check_slot("rst");
        reset_n = 1'b1;

        // all four requesting, ALU always ready: rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            rstep(4'b1111, 1'b1, 1'b0);
            chk("rr_seq_grant", last_grant, exp_seq[i]);
            chk("rr_seq_valid", alu_valid, 1'b1);
        end

        // load known entry, then hold ALU busy for three cycles
        step(4'b0001, 16'hFFF2, {96'h0, 32'd5}, {96'h0, 32'd7}, {18'h0, 6'd3}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rstep(4'b1111, 1'b0, 1'b0);
            chk("hold_grant", last_grant, 4'b0000);
            chk("hold_ctrl", alu_ctrl, 4'b0010);
            chk("hold_a", alu_op_a, 32'd5);
            chk("hold_b", alu_op_b, 32'd7);
            chk("hold_tag", alu_tag, 6'd3);
        end
        chk("hold_stall3", stall_cnt, 16'd3);

        // flush while blocked
        rstep(4'b1111, 1'b0, 1'b1);
        chk("flush_grant", last_grant, 4'b0000);
        chk("flush_valid", alu_valid, 1'b0);
        chk("flush_ptr", dut.rr_ptr, 2'd1);
        chk("flush_stall", stall_cnt, 16'd3);

        // lone requester 2: first moves pointer to 3, then wraps back to it
        rstep(4'b0100, 1'b1, 1'b0);
        chk("wrap_pre_ptr", dut.rr_ptr, 2'd3);
        rstep(4'b0100, 1'b1, 1'b0);
        chk("wrap_grant", last_grant, 4'b0100);
        chk("wrap_ptr", dut.rr_ptr, 2'd3);

        // async reset mid-cycle while full
        req_valid = 4'b1111; alu_ready = 1'b1; flush = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", alu_valid, 1'b0);
        chk("areset_ctrl", alu_ctrl, 4'b1111);
        chk("areset_grant", grant, 4'b0000);
        model_reset();
        @(posedge clk);
        #1;
        check_slot("areset");
        reset_n = 1'b1;
        rstep(4'b1111, 1'b1, 1'b0);
        chk("post_reset_grant", last_grant, 4'b0001);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rstep(4'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        // drive stall counter up to saturation
        rstep(4'b1111, 1'b1, 1'b0);
        req_valid = 4'b0000; alu_ready = 1'b0; flush = 1'b0;
        n_fill = 16'hFFFE - m_stall;
        repeat (n_fill) @(posedge clk);
        #1;
        m_stall = m_stall + n_fill;
        chk("sat_pre", stall_cnt, 16'hFFFE);
        rstep(4'b1111, 1'b0, 1'b0);
        rstep(4'b1111, 1'b0, 1'b0);
        chk("sat_max", stall_cnt, 16'hFFFF);
        rstep(4'b1111, 1'b0, 1'b0);
        rstep(4'b0011, 1'b0, 1'b0);
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of reservation-station requesters.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the operand width.
REQ-003 The block SHALL have parameter TAG_W, default 6, giving the destination-tag width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1, squash of the issue slot (mispredict recovery).
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, one request bit per requester.
REQ-008 The block SHALL have port req_ctrl, input, 4*NUM_REQ, packed 4-bit ALUControl per requester; requester i occupies bits [4i+3:4i].
REQ-009 The block SHALL have ports req_op_a and req_op_b, input, DATA_W*NUM_REQ each, packed operands, same slicing rule.
REQ-010 The block SHALL have port req_tag, input, TAG_W*NUM_REQ, packed destination tags.
REQ-011 The block SHALL have port grant, output, NUM_REQ, one-hot or zero; the requester drops the entry on the edge where grant is high.
REQ-012 The block SHALL have ports alu_valid (1), alu_ctrl (4), alu_op_a (DATA_W), alu_op_b (DATA_W) and alu_tag (TAG_W), all outputs, forming the registered issue slot.
REQ-013 The block SHALL have port alu_ready, input, 1, ALU acceptance of the issue slot.
REQ-014 The block SHALL have port stall_cnt, output, 16, saturating count of backpressure cycles.

Function
REQ-015 The issue slot SHALL be a two-state FSM: EMPTY (alu_valid=0) and FULL (alu_valid=1); alu_valid equals the state.
REQ-016 can_issue SHALL be defined as (EMPTY or alu_ready) and not flush.
REQ-017 grant SHALL be combinational, with at most one bit set, and SHALL be set only for a requester with req_valid=1 while can_issue=1.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, proceeds rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid requester wins.
REQ-019 On a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-020 On a grant, the winner's ctrl, op_a, op_b and tag SHALL load into the slot on the same edge; alu_valid is high after that edge (1-cycle latency).
REQ-021 Transitions: EMPTY with grant -> FULL; FULL with alu_ready and grant -> FULL with new contents (one issue per cycle); FULL with alu_ready and no grant -> EMPTY; FULL with alu_ready=0 -> FULL, contents held.
REQ-022 While FULL with alu_ready=0, every alu_* output SHALL remain bit-stable.
REQ-023 When flush=1, the next state SHALL be EMPTY regardless of alu_ready, grant SHALL be 0, and rr_ptr SHALL hold.
REQ-024 req_ctrl=4'b1111 (no-ALU op, e.g. LUI) SHALL be arbitrated and forwarded unchanged; the block SHALL NOT decode ctrl.
REQ-025 stall_cnt SHALL increment on each cycle with alu_valid=1, alu_ready=0 and flush=0, SHALL saturate at 16'hFFFF, and SHALL clear only on reset.
REQ-026 Request inputs of non-granted requesters SHALL have no effect on state.

Reset
REQ-027 While reset_n=0, the block SHALL force state EMPTY, alu_valid=0, alu_ctrl=4'b1111, alu_op_a=0, alu_op_b=0, alu_tag=0, rr_ptr=0, stall_cnt=0, and grant=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard the slot contents; after reset release, the first grant SHALL search from requester 0.

Verification
REQ-029 The bench SHALL cover: after reset, req_valid=4'b1111 with alu_ready=1 held -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, alu_valid high from the second cycle.
REQ-030 The bench SHALL cover: slot FULL with ctrl=4'b0010, op_a=5, op_b=7, tag=3, alu_ready=0 for 3 cycles -> grant=0 throughout, outputs stable, stall_cnt=3.
REQ-031 The bench SHALL cover: FULL with flush=1 and alu_ready=0 -> alu_valid=0 next cycle, grant=0 that cycle, rr_ptr unchanged.
REQ-032 The bench SHALL cover: only requester 2 valid with rr_ptr=3 -> grant=4'b0100 (wrap-around), rr_ptr becomes 3.
REQ-033 The bench SHALL cover: stall_cnt preloaded to 16'hFFFE by 2 further stall cycles -> value is 16'hFFFF and holds.
REQ-034 The bench SHALL cover: reset_n pulsed low while FULL -> alu_valid=0 and alu_ctrl=4'b1111 immediately, without waiting for a clock edge.
